// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle restoring radix-2^BPC signed/unsigned integer divider
module div_iter #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signdiv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done,
    output logic             busy,
    output logic             div_zero
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_n;

    // Operands as sampled with start
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;
    logic             sd_l;

    // Iteration datapath: quo shifts the dividend out and quotient bits in;
    // rem always holds a value below the divisor, so it fits in WIDTH bits.
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             accept;

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    // Magnitudes for signed mode; MIN maps to the unsigned value 2^(WIDTH-1)
    assign abs_a = (sd_l && a_l[WIDTH-1]) ? -a_l : a_l;
    assign abs_b = (sd_l && b_l[WIDTH-1]) ? -b_l : b_l;

    // BPC restoring shift/subtract steps unrolled into one cycle
    always_comb begin
        quo_n = quo;
        rem_n = rem;
        trial = '0;
        for (int i = 0; i < BPC; i++) begin
            trial = {rem_n, quo_n[WIDTH-1]};
            quo_n = {quo_n[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, dvs}) begin
                trial    = trial - {1'b0, dvs};
                quo_n[0] = 1'b1;
            end
            rem_n = trial[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_PREP;
            S_PREP:  state_n = (b_l == '0) ? S_DONE : S_CALC;
            S_CALC:  if (cnt == CW'(1)) state_n = S_FIX;
            S_FIX:   state_n = S_DONE;
            S_DONE:  state_n = start ? S_PREP : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_PREP, S_CALC, S_FIX: busy = 1'b1;
            S_DONE:                done = 1'b1;
            default:               ;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_l      <= '0;
            b_l      <= '0;
            sd_l     <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            if (accept) begin
                a_l  <= a;
                b_l  <= b;
                sd_l <= signdiv;
            end
            case (state)
                S_PREP: begin
                    if (b_l == '0) begin
                        q        <= '1;
                        r        <= a_l;
                        div_zero <= 1'b1;
                    end else begin
                        quo    <= abs_a;
                        dvs    <= abs_b;
                        rem    <= '0;
                        cnt    <= CW'(STEPS);
                        sign_q <= a_l[WIDTH-1] ^ b_l[WIDTH-1];
                        sign_r <= a_l[WIDTH-1];
                    end
                end
                S_CALC: begin
                    quo <= quo_n;
                    rem <= rem_n;
                    cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    q        <= (sd_l && sign_q) ? -quo : quo;
                    r        <= (sd_l && sign_r) ? -rem : rem;
                    div_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
